uart_tx_cfg: RTL and testbench

// - Runtime-configurable UART transmitter; next generation of the SDI-aulas tx block.
// - Has an internal baud divider and a valid/ready input handshake.
// - Data length, parity mode and stop-bit count are programmable per frame.
// - Sits between a byte producer (CPU regs/FIFO) and the serial pin; one frame in flight at a time.

---
 rtl/uart_tx_cfg.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with baud divider and valid/ready input.
// Define UART_TX_BREAK_EN to add the send_break input and the BREAK state.
module uart_tx_cfg #(
    parameter int DATA_W = 9,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [3:0]        data_len,
    input  logic [2:0]        parity_mode,
    input  logic              stop2,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx_out,
    output logic              busy,
    output logic              tx_done
`ifdef UART_TX_BREAK_EN
    ,
    input  logic              send_break
`endif
);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

    localparam logic [3:0] LEN_MAX = 4'(DATA_W);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic               stop_last_q, stop_last_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               load;
    logic               go_stop, stop_two;

    logic [DIV_W-1:0]   div_l;
    logic [3:0]         len_l;
    logic               par_en_l, par_bit_l, stop2_l;

    logic [DIV_W-1:0]   div_eff;
    logic [3:0]         len_eff;
    logic               par_en_in, par_bit_in, data_xor;
    logic [DIV_W-1:0]   reload;

    assign div_eff   = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign len_eff   = (data_len < 4'd5) ? 4'd5 : ((data_len > LEN_MAX) ? LEN_MAX : data_len);
    assign par_en_in = (parity_mode >= 3'd1) && (parity_mode <= 3'd4);
    assign reload    = div_l - DIV_W'(1);

    always_comb begin
        data_xor = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i < 32'(len_eff)) data_xor = data_xor ^ data_in[i];
        end
    end

    always_comb begin
        case (parity_mode)
            3'd1:    par_bit_in = data_xor;
            3'd2:    par_bit_in = ~data_xor;
            3'd3:    par_bit_in = 1'b1;
            default: par_bit_in = 1'b0;
        endcase
    end

`ifdef UART_TX_BREAK_EN
    logic [3:0] brk_tgt_l, brk_tgt_in;
    logic       brk_met;
    assign brk_tgt_in = len_eff + {3'b000, par_en_in} + (stop2 ? 4'd2 : 4'd1) + 4'd1;
    // Hold is met once the current cycle completes the final required bit period.
    assign brk_met    = (idx_q == brk_tgt_l) || ((idx_q + 4'd1 == brk_tgt_l) && (cnt_q == '0));
    assign in_ready   = (state_q == S_IDLE) && !send_break;
`else
    assign in_ready   = (state_q == S_IDLE);
`endif
    assign busy    = ~in_ready;
    assign tx_out  = tx_q;
    assign tx_done = done_q;

    // The FSM returns to IDLE one cycle early so the last stop-bit cycle can accept a new frame.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stop_last_d = stop_last_q;
        shift_d     = shift_q;
        tx_d        = 1'b1;
        done_d      = 1'b0;
        load        = 1'b0;
        go_stop     = 1'b0;
        stop_two    = stop2_l;
        case (state_q)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (send_break) begin
                    load    = 1'b1;
                    state_d = S_BREAK;
                    cnt_d   = div_eff - DIV_W'(1);
                    idx_d   = '0;
                    tx_d    = 1'b0;
                end else
`endif
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = S_START;
                    cnt_d   = div_eff - DIV_W'(1);
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    cnt_d   = reload;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (cnt_q == '0) begin
                    if (idx_q == len_l - 4'd1) begin
                        if (par_en_l) begin
                            state_d = S_PARITY;
                            cnt_d   = reload;
                            tx_d    = par_bit_l;
                        end else begin
                            go_stop = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = reload;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_PARITY: begin
                tx_d = par_bit_l;
                if (cnt_q == '0) go_stop = 1'b1;
                else             cnt_d = cnt_q - DIV_W'(1);
            end
            S_STOP: begin
                if (stop_last_q) begin
                    if (cnt_q == DIV_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end
                end else if (cnt_q == '0) begin
                    if (div_l == DIV_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_last_d = 1'b1;
                        cnt_d       = reload;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                tx_d     = 1'b0;
                stop_two = 1'b0;
                if (!send_break && brk_met) begin
                    go_stop = 1'b1;
                end else if (cnt_q == '0) begin
                    cnt_d = reload;
                    if (idx_q != brk_tgt_l) idx_d = idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (go_stop) begin
            tx_d = 1'b1;
            if (stop_two) begin
                state_d     = S_STOP;
                stop_last_d = 1'b0;
                cnt_d       = reload;
            end else if (div_l == DIV_W'(1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d     = S_STOP;
                stop_last_d = 1'b1;
                cnt_d       = reload;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_last_q <= 1'b0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
            div_l       <= DIV_W'(1);
            len_l       <= 4'd5;
            par_en_l    <= 1'b0;
            par_bit_l   <= 1'b0;
            stop2_l     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_tgt_l   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stop_last_q <= stop_last_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
            if (load) begin
                shift_q   <= data_in;
                div_l     <= div_eff;
                len_l     <= len_eff;
                par_en_l  <= par_en_in;
                par_bit_l <= par_bit_in;
                stop2_l   <= stop2;
`ifdef UART_TX_BREAK_EN
                brk_tgt_l <= brk_tgt_in;
`endif
            end else begin
                shift_q <= shift_d;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: per-cycle frame model plus directed literal checks.
// Break checks are compiled in when UART_TX_BREAK_EN is defined.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = 16'd1;
    logic [3:0]  data_len = 4'd8;
    logic [2:0]  parity_mode = 3'd0;
    logic        stop2 = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  data_in = '0;
    logic        tx_out;
    logic        busy;
    logic        tx_done;
    logic        send_break = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(9), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .data_len   (data_len),
        .parity_mode(parity_mode),
        .stop2      (stop2),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done)
`ifdef UART_TX_BREAK_EN
        ,
        .send_break (send_break)
`endif
    );

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: one queue entry per expected line cycle, filled at acceptance.
    typedef struct packed { logic tx; logic done; } cyc_t;
    cyc_t exp_q[$];
    bit   brk_active = 0;
    int   brk_cyc = 0, brk_min = 0, brk_d = 1;
    bit   model_idle;

    function automatic int eff_div(input logic [15:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    function automatic int eff_len(input logic [3:0] l);
        if (l < 5) return 5;
        if (l > 9) return 9;
        return int'(l);
    endfunction

    function automatic void push_bit(input logic b, input int d);
        cyc_t c;
        for (int i = 0; i < d; i++) begin
            c.tx = b; c.done = 1'b0;
            exp_q.push_back(c);
        end
    endfunction

    function automatic void push_frame(input logic [15:0] div, input logic [3:0] len,
                                       input logic [2:0] pm, input logic s2, input logic [8:0] d);
        int D, L, ones;
        cyc_t last;
        D = eff_div(div);
        L = eff_len(len);
        ones = 0;
        push_bit(1'b0, D);
        for (int i = 0; i < L; i++) begin
            push_bit(d[i], D);
            ones += int'(d[i]);
        end
        case (pm)
            3'd1: push_bit(1'(ones % 2), D);
            3'd2: push_bit(1'(1 - ones % 2), D);
            3'd3: push_bit(1'b1, D);
            3'd4: push_bit(1'b0, D);
            default: ;
        endcase
        push_bit(1'b1, D);
        if (s2) push_bit(1'b1, D);
        last = exp_q.pop_back();
        last.done = 1'b1;
        exp_q.push_back(last);
    endfunction

    function automatic logic model_rdy();
        return !brk_active && (exp_q.size() == 0 || exp_q[0].done) && !send_break;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            brk_active = 0;
            brk_cyc = 0;
        end else if (brk_active) begin
            brk_cyc++;
            if (brk_cyc >= brk_min && !send_break) begin
                cyc_t c;
                brk_active = 0;
                push_bit(1'b1, brk_d);
                c = exp_q.pop_back();
                c.done = 1'b1;
                exp_q.push_back(c);
            end
        end else begin
            model_idle = (exp_q.size() == 0) || exp_q[0].done;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (model_idle && send_break) begin
                brk_active = 1;
                brk_cyc = 0;
                brk_d = eff_div(baud_div);
                brk_min = (eff_len(data_len) + ((parity_mode >= 1 && parity_mode <= 4) ? 1 : 0)
                           + (stop2 ? 2 : 1) + 1) * brk_d;
            end else if (model_idle && in_valid) begin
                push_frame(baud_div, data_len, parity_mode, stop2, data_in);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic etx, edone, erdy;
            if (brk_active) begin
                etx = 1'b0; edone = 1'b0;
            end else if (exp_q.size() > 0) begin
                etx = exp_q[0].tx; edone = exp_q[0].done;
            end else begin
                etx = 1'b1; edone = 1'b0;
            end
            erdy = model_rdy();
            chk("tx_out", int'(tx_out), int'(etx));
            chk("tx_done", int'(tx_done), int'(edone));
            chk("in_ready", int'(in_ready), int'(erdy));
            chk("busy", int'(busy), int'(!erdy));
        end
    end

    logic cap_tx [0:127];
    logic cap_done [0:127];

    task automatic capture(input int n);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            cap_tx[j] = tx_out;
            cap_done[j] = tx_done;
        end
    endtask

    // Returns just after the accepting edge; the next negedge samples cycle 1.
    task automatic start_frame(input logic [15:0] div, input logic [3:0] len, input logic [2:0] pm,
                               input logic s2, input logic [8:0] d, input bit keep);
        int k;
        @(negedge clk);
        baud_div = div; data_len = len; parity_mode = pm; stop2 = s2; data_in = d;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", int'(in_ready), 1);
        if (!in_ready) begin
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (!keep) begin
                #1;
                in_valid = 1'b0;
                // Config inputs wander mid-frame; the latched values must win.
                baud_div = 16'd7; data_len = 4'd6; parity_mode = 3'd1; stop2 = ~s2; data_in = ~d;
            end
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  p1;
        logic [10:0] p2;
        p1 = 10'b1101001010;
        p2 = 11'b11010000010;

        repeat (3) @(negedge clk);
        chk("rst_tx_out", int'(tx_out), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_done", int'(tx_done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, D=4, 0xA5
        start_frame(16'd4, 4'd8, 3'd0, 1'b0, 9'h0A5, 0);
        capture(41);
        for (int j = 1; j <= 40; j++) begin
            chk("t1_tx", int'(cap_tx[j]), int'(p1[(j-1)/4]));
            chk("t1_done", int'(cap_done[j]), (j == 40) ? 1 : 0);
        end
        chk("t1_idle_tx", int'(cap_tx[41]), 1);
        wait_idle();

        // 7E2, D=2, 0x41
        start_frame(16'd2, 4'd7, 3'd1, 1'b1, 9'h041, 0);
        capture(22);
        for (int j = 1; j <= 22; j++) begin
            chk("t2_tx", int'(cap_tx[j]), int'(p2[(j-1)/2]));
            chk("t2_done", int'(cap_done[j]), (j == 22) ? 1 : 0);
        end
        wait_idle();

        // 8O1, D=1, 0x55 with in_valid held for a back-to-back second frame
        start_frame(16'd1, 4'd8, 3'd2, 1'b0, 9'h055, 1);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            cap_tx[j] = tx_out;
            cap_done[j] = tx_done;
            if (j == 1) data_in = 9'h0F3;
            if (j == 12) in_valid = 1'b0;
        end
        chk("t3_parity", int'(cap_tx[10]), 1);
        chk("t3_done_early", int'(cap_done[10]), 0);
        chk("t3_done", int'(cap_done[11]), 1);
        chk("t3_stop", int'(cap_tx[11]), 1);
        chk("t3_b2b_start", int'(cap_tx[12]), 0);
        wait_idle();

        // baud_div 0 acts as 1; length clamps at both ends
        start_frame(16'd0, 4'd3, 3'd0, 1'b0, 9'h015, 0);
        capture(8);
        chk("t4a_b0", int'(cap_tx[2]), 1);
        chk("t4a_b1", int'(cap_tx[3]), 0);
        chk("t4a_b4", int'(cap_tx[6]), 1);
        chk("t4a_done_early", int'(cap_done[6]), 0);
        chk("t4a_done", int'(cap_done[7]), 1);
        wait_idle();

        start_frame(16'd0, 4'd15, 3'd6, 1'b0, 9'h100, 0);
        capture(12);
        chk("t4b_b7", int'(cap_tx[9]), 0);
        chk("t4b_b8", int'(cap_tx[10]), 1);
        chk("t4b_done_early", int'(cap_done[10]), 0);
        chk("t4b_done", int'(cap_done[11]), 1);
        chk("t4b_idle", int'(cap_tx[12]), 1);
        wait_idle();

        // Asynchronous reset during the data phase
        start_frame(16'd3, 4'd8, 3'd2, 1'b0, 9'h0AA, 0);
        repeat (5) @(negedge clk);
        chk("pre_rst_tx", int'(tx_out), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", int'(tx_out), 1);
        chk("async_rst_ready", int'(in_ready), 1);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(tx_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        start_frame(16'd2, 4'd5, 3'd3, 1'b1, 9'h013, 0);
        capture(18);
        chk("t5_b2", int'(cap_tx[7]), 0);
        chk("t5_b4", int'(cap_tx[11]), 1);
        chk("t5_mark", int'(cap_tx[13]), 1);
        chk("t5_done_early", int'(cap_done[17]), 0);
        chk("t5_done", int'(cap_done[18]), 1);
        wait_idle();

        // A few more frames checked by the model only
        start_frame(16'd5, 4'd9, 3'd4, 1'b1, 9'h1FF, 0);
        wait_idle();
        start_frame(16'd3, 4'd6, 3'd2, 1'b0, 9'h02D, 0);
        wait_idle();
        start_frame(16'd1, 4'd9, 3'd1, 1'b1, 9'h135, 0);
        wait_idle();

`ifdef UART_TX_BREAK_EN
        // Break for 100 cycles, 8N1 at D=2, with in_valid waiting behind it
        @(posedge clk);
        #1;
        baud_div = 16'd2; data_len = 4'd8; parity_mode = 3'd0; stop2 = 1'b0;
        data_in = 9'h03C; in_valid = 1'b1; send_break = 1'b1;
        for (int j = 1; j <= 103; j++) begin
            @(posedge clk);
            #1;
            if (j == 100) send_break = 1'b0;
            @(negedge clk);
            cap_tx[j] = tx_out;
            cap_done[j] = tx_done;
        end
        in_valid = 1'b0;
        begin
            int lows;
            lows = 0;
            for (int j = 1; j <= 100; j++) lows += (cap_tx[j] == 1'b0) ? 1 : 0;
            chk("brk_low_cycles", lows, 100);
        end
        chk("brk_stop1_tx", int'(cap_tx[101]), 1);
        chk("brk_stop1_done", int'(cap_done[101]), 0);
        chk("brk_stop2_tx", int'(cap_tx[102]), 1);
        chk("brk_done", int'(cap_done[102]), 1);
        chk("brk_deferred_start", int'(cap_tx[103]), 0);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
